// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues single-word reads to instruction
// memory and hands each fetched word with its PC to decode over valid/ready.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_imm,
  output logic        fetch_error
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  // Handshake: decode takes instr/instr_pc on a rising edge where
  // instr_valid=1 and instr_ready=1, unless branch_taken squashes it that cycle.
  logic [1:0]  state;
  logic [31:0] pc;
  logic        flush_pending;
  logic [31:0] target;

  // branch_imm carries the raw B-type immediate; bit 0 of the offset is implicit.
  assign target    = branch_pc + {{19{branch_imm[11]}}, branch_imm[11:0], 1'b0};
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      instr         <= 32'h0;
      instr_pc      <= 32'h0;
      instr_valid   <= 1'b0;
      fetch_error   <= 1'b0;
      flush_pending <= 1'b0;
    end else if (branch_taken && state != ERROR) begin
      if (target[1]) begin
        fetch_error <= 1'b1;
        instr_valid <= 1'b0;
        state       <= ERROR;
      end else begin
        pc <= target;
        case (state)
          FETCH: begin
            // The request just issued returns data for the old path.
            flush_pending <= 1'b1;
            state         <= WAIT;
          end
          WAIT: begin
            if (imem_rvalid) begin
              flush_pending <= 1'b0;
              state         <= FETCH;
            end else begin
              flush_pending <= 1'b1;
            end
          end
          default: begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        endcase
      end
    end else begin
      case (state)
        FETCH: state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (flush_pending) begin
              flush_pending <= 1'b0;
              state         <= FETCH;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-programmable memory model plus
// scoreboard queues of expected fetch addresses and delivered instructions.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] branch_imm;
  logic        fetch_error;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch_taken(branch_taken),
    .branch_pc   (branch_pc),
    .branch_imm  (branch_imm),
    .fetch_error (fetch_error)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [63:0] exp_instr_q[$];

  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory: answers each request after lat cycles; drives garbage otherwise.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = lat - 1;
      end
    end
  end

  // Scoreboard: every request and every accepted instruction must be expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL req_extra observed=%0h expected=none", imem_addr);
        end else begin
          chk("req_addr", {32'h0, imem_addr}, {32'h0, exp_q.pop_front()});
        end
      end
      if (instr_valid && instr_ready && !branch_taken) begin
        if (exp_instr_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL instr_extra observed=%0h expected=none", {instr_pc, instr});
        end else begin
          chk("instr", {instr_pc, instr}, exp_instr_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    instr_ready  = 1'b1;
    branch_taken = 1'b0;
    branch_pc    = 32'h0;
    branch_imm   = 32'h0;
    step(2);
    chk("rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk("rst_instr_pc", {32'h0, instr_pc}, 64'h0);
    chk("rst_error", {63'h0, fetch_error}, 64'h0);
    chk("rst_addr", {32'h0, imem_addr}, 64'h0);
    chk("rst_req", {63'h0, imem_req}, 64'h1);

    // Sequential fetch with zero-wait memory: one request every 3 cycles.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    exp_instr_q.push_back({32'h0, mem_word(32'h0)});
    exp_instr_q.push_back({32'h4, mem_word(32'h4)});
    exp_instr_q.push_back({32'h8, mem_word(32'h8)});
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("seq_req", {63'h0, imem_req}, {63'h0, (i % 3) == 0});
      chk("seq_valid", {63'h0, instr_valid}, {63'h0, (i % 3) == 2});
      step(1);
    end

    // Backpressure on the word at 0x8.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {63'h0, instr_valid}, 64'h1);
      chk("bp_pc", {32'h0, instr_pc}, 64'h8);
      chk("bp_instr", {32'h0, instr}, {32'h0, mem_word(32'h8)});
      chk("bp_req", {63'h0, imem_req}, 64'h0);
      step(1);
    end
    instr_ready = 1'b1;
    step(1);
    chk("bp_next_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'hC});

    // Branch while holding 0xC, decode ready the same cycle: squash.
    step(2);
    chk("hold_valid", {32'h0, instr_pc}, 64'hC);
    exp_q.push_back(32'h0);
    branch_taken = 1'b1;
    branch_pc    = 32'h10;
    branch_imm   = 32'h0000_0FF8;
    step(1);
    branch_taken = 1'b0;
    chk("hold_squash", {63'h0, instr_valid}, 64'h0);
    chk("hold_redirect", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    lat = 3;

    // Branch during WAIT with slow memory: returning word discarded.
    step(1);
    exp_q.push_back(32'h24);
    branch_taken = 1'b1;
    branch_pc    = 32'h4;
    branch_imm   = 32'h0000_0010;
    step(1);
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("wait_no_valid", {62'h0, instr_valid, imem_req}, 64'h0);
      step(1);
    end
    chk("wait_redirect", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h24});
    exp_instr_q.push_back({32'h24, mem_word(32'h24)});
    step(1);
    lat = 1;
    step(3);
    chk("slow_valid", {31'h0, instr_valid, instr_pc}, {31'h0, 1'b1, 32'h24});
    exp_q.push_back(32'h28);

    // Branch coinciding with rvalid, then wrap from 0xFFFF_FFFC.
    step(2);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_instr_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    branch_taken = 1'b1;
    branch_pc    = 32'hFFFF_FFF0;
    branch_imm   = 32'h0000_0006;
    step(1);
    branch_taken = 1'b0;
    chk("same_cyc_valid", {63'h0, instr_valid}, 64'h0);
    chk("same_cyc_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'hFFFF_FFFC});
    exp_q.push_back(32'h0);
    exp_instr_q.push_back({32'h0, mem_word(32'h0)});
    step(3);
    chk("wrap_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    exp_q.push_back(32'h4);
    step(3);
    chk("pre_mis_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h4});

    // Misaligned target: sticky error until reset.
    branch_taken = 1'b1;
    branch_pc    = 32'h0;
    branch_imm   = 32'h0000_0001;
    step(1);
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("err_flag", {63'h0, fetch_error}, 64'h1);
      chk("err_quiet", {62'h0, imem_req, instr_valid}, 64'h0);
      chk("err_pc", {32'h0, imem_addr}, 64'h4);
      step(1);
    end
    rst_n = 1'b0;
    step(1);
    chk("rerst_error", {63'h0, fetch_error}, 64'h0);
    chk("rerst_addr", {32'h0, imem_addr}, 64'h0);
    chk("rerst_out", {instr_pc, instr}, 64'h0);
    chk("rerst_valid", {63'h0, instr_valid}, 64'h0);
    exp_q.push_back(32'h0);
    exp_instr_q.push_back({32'h0, mem_word(32'h0)});
    rst_n = 1'b1;
    step(3);
    chk("addr_q_empty", {32'h0, exp_q.size()}, 64'h0);
    chk("instr_q_empty", {32'h0, exp_instr_q.size()}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
